// File: rtl/store_drain_buffer_if.sv
// Store / load / memory-port bundle of the committed-store drain buffer.
// The slave modport is the buffer's own view; the master modport is the
// view of whatever surrounds it (pipeline plus data memory).
interface store_drain_buffer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  st_valid;
    logic                  st_ready;
    logic [ADDR_WIDTH-1:0] st_addr;
    logic [DATA_WIDTH-1:0] st_data;

    logic                  ld_req_valid;
    logic                  ld_req_ready;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic                  ld_resp_valid;
    logic [DATA_WIDTH-1:0] ld_resp_data;
    logic                  ld_resp_fwd;

    logic                  sb_empty;

    logic                  mem_write_en;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rdata_valid;

    modport slave (
        input  st_valid, st_addr, st_data, ld_req_valid, ld_addr, rdata, rdata_valid,
        output st_ready, ld_req_ready, ld_resp_valid, ld_resp_data, ld_resp_fwd,
               sb_empty, mem_write_en, waddr, wdata, mem_rd_en, raddr
    );

    modport master (
        output st_valid, st_addr, st_data, ld_req_valid, ld_addr, rdata, rdata_valid,
        input  st_ready, ld_req_ready, ld_resp_valid, ld_resp_data, ld_resp_fwd,
               sb_empty, mem_write_en, waddr, wdata, mem_rd_en, raddr
    );
endinterface

// File: rtl/store_drain_buffer.sv
// Committed-store FIFO in front of the data-memory port. Stores drain one
// per cycle from the head; loads are forwarded from the youngest matching
// buffered store or, on a miss, read from memory with draining frozen until
// the read data returns so memory cannot change under the outstanding read.
module store_drain_buffer #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    store_drain_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_ISSUE = 2'd1,
        LD_WAIT  = 2'd2,
        LD_RESP  = 2'd3
    } ld_state_t;

    logic [ADDR_WIDTH-1:0] addr_mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_r [DEPTH];
    logic [PTR_W-1:0]      head_r;
    logic [PTR_W-1:0]      tail_r;
    logic [CNT_W-1:0]      count_r;

    ld_state_t             state_r;
    logic                  ld_req_ready_r;
    logic                  mem_rd_en_r;
    logic [ADDR_WIDTH-1:0] raddr_r;
    logic                  ld_resp_valid_r;
    logic [DATA_WIDTH-1:0] ld_resp_data_r;
    logic                  ld_resp_fwd_r;

    logic                  enq_s;
    logic                  deq_s;
    logic                  drain_ok_s;
    logic                  fwd_hit_s;
    logic [DATA_WIDTH-1:0] fwd_data_s;

    // Handshake and drain qualification; draining pauses while a memory read is in flight.
    always_comb begin
        drain_ok_s = (state_r != LD_ISSUE) && (state_r != LD_WAIT);
        enq_s      = bus.st_valid && (count_r != DEPTH_C);
        deq_s      = (count_r != {CNT_W{1'b0}}) && drain_ok_s;
    end

    // Forwarding search: walk oldest to youngest so the youngest match wins, incoming store last.
    always_comb begin
        logic [PTR_W-1:0] idx_v;
        logic             match_v;
        fwd_hit_s  = 1'b0;
        fwd_data_s = {DATA_WIDTH{1'b0}};
        idx_v      = head_r;
        match_v    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx_v      = head_r + PTR_W'(i);
            match_v    = (CNT_W'(i) < count_r) &&
                         (addr_mem_r[idx_v][ADDR_WIDTH-1:2] == bus.ld_addr[ADDR_WIDTH-1:2]);
            fwd_hit_s  = fwd_hit_s | match_v;
            fwd_data_s = match_v ? data_mem_r[idx_v] : fwd_data_s;
        end
        match_v    = enq_s && (bus.st_addr[ADDR_WIDTH-1:2] == bus.ld_addr[ADDR_WIDTH-1:2]);
        fwd_hit_s  = fwd_hit_s | match_v;
        fwd_data_s = match_v ? bus.st_data : fwd_data_s;
    end

    // Entry storage: written at the tail on every accepted store.
    always_ff @(posedge clk) begin
        if (rst && enq_s) begin
            addr_mem_r[tail_r] <= bus.st_addr;
            data_mem_r[tail_r] <= bus.st_data;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (enq_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end else begin
                tail_r <= tail_r;
            end
            if (deq_s) begin
                head_r <= head_r + PTR_W'(1);
            end else begin
                head_r <= head_r;
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Load FSM with registered outputs; pulses are set on entry to ISSUE/RESP and cleared otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r         <= LD_IDLE;
            ld_req_ready_r  <= 1'b1;
            mem_rd_en_r     <= 1'b0;
            raddr_r         <= {ADDR_WIDTH{1'b0}};
            ld_resp_valid_r <= 1'b0;
            ld_resp_data_r  <= {DATA_WIDTH{1'b0}};
            ld_resp_fwd_r   <= 1'b0;
        end else begin
            mem_rd_en_r     <= 1'b0;
            ld_resp_valid_r <= 1'b0;
            ld_resp_data_r  <= {DATA_WIDTH{1'b0}};
            ld_resp_fwd_r   <= 1'b0;
            case (state_r)
                LD_IDLE: begin
                    if (bus.ld_req_valid && fwd_hit_s) begin
                        state_r         <= LD_RESP;
                        ld_req_ready_r  <= 1'b0;
                        ld_resp_valid_r <= 1'b1;
                        ld_resp_data_r  <= fwd_data_s;
                        ld_resp_fwd_r   <= 1'b1;
                    end else if (bus.ld_req_valid) begin
                        state_r        <= LD_ISSUE;
                        ld_req_ready_r <= 1'b0;
                        mem_rd_en_r    <= 1'b1;
                        raddr_r        <= bus.ld_addr;
                    end else begin
                        state_r        <= LD_IDLE;
                        ld_req_ready_r <= 1'b1;
                    end
                end
                LD_ISSUE: begin
                    state_r        <= LD_WAIT;
                    ld_req_ready_r <= 1'b0;
                end
                LD_WAIT: begin
                    ld_req_ready_r <= 1'b0;
                    if (bus.rdata_valid) begin
                        state_r         <= LD_RESP;
                        ld_resp_valid_r <= 1'b1;
                        ld_resp_data_r  <= bus.rdata;
                    end else begin
                        state_r <= LD_WAIT;
                    end
                end
                LD_RESP: begin
                    state_r        <= LD_IDLE;
                    ld_req_ready_r <= 1'b1;
                end
                default: begin
                    state_r        <= LD_IDLE;
                    ld_req_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.st_ready      = (count_r != DEPTH_C);
    assign bus.sb_empty      = (count_r == {CNT_W{1'b0}});
    assign bus.mem_write_en  = deq_s;
    assign bus.waddr         = addr_mem_r[head_r];
    assign bus.wdata         = data_mem_r[head_r];
    assign bus.mem_rd_en     = mem_rd_en_r;
    assign bus.raddr         = raddr_r;
    assign bus.ld_req_ready  = ld_req_ready_r;
    assign bus.ld_resp_valid = ld_resp_valid_r;
    assign bus.ld_resp_data  = ld_resp_data_r;
    assign bus.ld_resp_fwd   = ld_resp_fwd_r;
endmodule

// File: doc/store_drain_buffer.md
Name: store_drain_buffer

Overview:
- Committed-store buffer and load port sitting directly upstream of the data-memory port of the Memory block: it drives mem_write_en/waddr/wdata and mem_rd_en/raddr, and consumes rdata/rdata_valid.
- Holds retired stores in a FIFO and drains them to memory one per cycle.
- Serves load requests by store-to-load forwarding from the buffer or, on a miss, by a memory read.
- Word granularity only: all accesses are word-aligned full-width words.

Parameters:
- DEPTH, 8, number of store entries (power of two, >= 2)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width

Ports:
- clk  input  1  single clock, all state updates on posedge
- rst  input  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
- st_valid  input  1  committed store offered
- st_ready  output  1  buffer can accept a store
- st_addr  input  ADDR_WIDTH  store address (word aligned)
- st_data  input  DATA_WIDTH  store data
- ld_req_valid  input  1  load request
- ld_req_ready  output  1  load port idle
- ld_addr  input  ADDR_WIDTH  load address (word aligned)
- ld_resp_valid  output  1  one-cycle pulse, ld_resp_data valid
- ld_resp_data  output  DATA_WIDTH  load result
- ld_resp_fwd  output  1  qualifies ld_resp_valid; 1 = served from buffer
- sb_empty  output  1  no stores pending (used for fences)
- mem_write_en  output  1  to Memory
- waddr  output  ADDR_WIDTH  to Memory
- wdata  output  DATA_WIDTH  to Memory
- mem_rd_en  output  1  to Memory, one-cycle pulse
- raddr  output  ADDR_WIDTH  to Memory
- rdata  input  DATA_WIDTH  from Memory
- rdata_valid  input  1  from Memory

Behaviour:
- Reset (rst=0 at posedge):
  - FIFO emptied: head, tail and count = 0; load FSM = IDLE.
  - All registered outputs = 0; sb_empty = 1, st_ready = 1, ld_req_ready = 1.
  - Reset mid-operation aborts any pending load with no response; buffered stores are discarded.
- Store FIFO:
  - st_ready = (count != DEPTH). Enqueue when st_valid && st_ready.
  - When full, st_ready stays 0 even if a drain happens the same cycle; the slot becomes visible the next cycle.
  - Pointers wrap modulo DEPTH.
- Drain (combinational outputs from the head entry):
  - mem_write_en = (count != 0) && drain_ok, with waddr/wdata = head entry; the head pops in the same cycle.
  - drain_ok = 0 in states ISSUE and WAIT, else 1.
  - Simultaneous enqueue and drain: count unchanged.
  - sb_empty = (count == 0).
- Load FSM with states IDLE, ISSUE, WAIT, RESP:
  - IDLE: ld_req_ready = 1. Acceptance on ld_req_valid at cycle T.
  - Forwarding compare on addr[ADDR_WIDTH-1:2]. The compare covers all valid entries plus the store being enqueued at T; the youngest match wins, and the incoming store is youngest.
  - Head being drained at T is still searched.
  - Hit: -> RESP, data latched.
  - Miss: -> ISSUE, ld_addr latched.
  - ISSUE (one cycle): mem_rd_en = 1, raddr = latched address; -> WAIT.
  - WAIT: hold until rdata_valid; latch rdata; -> RESP. If rdata_valid arrives in the ISSUE cycle, it is ignored.
  - RESP (one cycle): ld_resp_valid = 1, ld_resp_data = latched value, ld_resp_fwd = 1 for a hit; -> IDLE. ld_req_ready = 0 here.
- Latency (acceptance to ld_resp_valid):
  - Hit: 1 cycle.
  - Miss: 2 cycles + memory latency, where memory latency is counted from the mem_rd_en cycle to rdata_valid.
- Draining is stalled during ISSUE/WAIT so memory contents cannot change under an outstanding read.
- Stores continue to enqueue in every state.
- ld_resp_data and ld_resp_fwd read 0 outside RESP.

Test Plan:
- Reset then 3 stores (0x1000=0x11, 0x1004=0x22, 0x1008=0x33) with no loads -> mem_write_en high for 3 consecutive cycles, starting the cycle after the first enqueue, in FIFO order; sb_empty returns to 1.
- Load 0x1004 while two entries at 0x1004 are pending (0xAA older, 0xBB younger) -> ld_resp_valid at T+1, ld_resp_data = 0xBB, ld_resp_fwd = 1.
- Load 0x2000 with an empty buffer and memory holding 0xDEADBEEF -> mem_rd_en pulse at T+1 with raddr = 0x2000; response the cycle after rdata_valid with ld_resp_fwd = 0.
- Same-cycle store 0x1010=0x55 and load 0x1010 -> forwarded result 0x55 at T+1.
- Stall and fill: hold rdata_valid low while offering DEPTH+1 stores -> no mem_write_en during WAIT; st_ready drops after 8 enqueues. Release rdata_valid -> draining resumes, and no enqueue happens while full.
- Assert rst=0 during WAIT with 4 stores pending -> next cycle sb_empty = 1, ld_req_ready = 1, no ld_resp_valid, no mem writes.
